mult_core: RTL
==============

# mult_core

Parametrised shift-add multiplier core: a WIDTH-bit multiplicand register S, an accumulator A with sign/carry bit X, and a multiplier/product register B, sequenced by an internal FSM. It generalises the lab's 8-bit A/B register pair and separate controller into one block. It supports signed (two's-complement) and unsigned operation, latches its operands at start, and exposes a Busy/Done handshake to the top-level I/O and hex-display logic.

## Interface
- WIDTH, 8, operand width in bits; legal range 2–32.
- Clk  input  1  sole clock; all state updates on rising edge.
- Reset  input  1  synchronous, active-high; overrides every other input.
- Start  input  1  level request; sampled only in IDLE.
- ClearA_LoadB  input  1  in IDLE: clear A and X, load B from Sw.
- Signed_Mode  input  1  1 = signed multiply, 0 = unsigned; latched at Start.
- Sw  input  WIDTH  operand input; B source on load, S source at Start.
- Aval  output  WIDTH  A register (product high half).
- Bval  output  WIDTH  B register (product low half).
- Xval  output  1  X bit (signed: sign of A; unsigned: adder carry).
- Busy  output  1  high in CLEAR, ADD, SHIFT.
- Done  output  1  high in DONE; {Aval,Bval} is the valid 2·WIDTH product.

## Operation
- Reset: A=0, B=0, S=0, X=0, count=0, mode=0, state IDLE, Busy=0, Done=0.
- IDLE: ClearA_LoadB high → A=0, X=0, B=Sw. If Start is also high in the same cycle, ClearA_LoadB wins and Start is ignored for that cycle; a Start still high is taken on the next edge. Start high, ClearA_LoadB low → S=Sw, mode=Signed_Mode, → CLEAR.
- CLEAR (1 cycle): A=0, X=0, count=0 → ADD.
- ADD (1 cycle): if B[0]=1, {X,A} = ext(A) ± ext(S), computed at WIDTH+1 bits. Subtract only when mode=1 and count=WIDTH-1; otherwise add. ext = sign-extend when mode=1 and zero-extend when mode=0. If B[0]=0, A and X hold. → SHIFT.
- SHIFT (1 cycle): A = {X, A[WIDTH-1:1]}, B = {A[0], B[WIDTH-1:1]}.
  - mode=1: X holds (arithmetic shift).
  - mode=0: X is cleared.
  - Then count+1. If the old count = WIDTH-1 → DONE, else → ADD.
- DONE: all registers hold. Leave for IDLE only when Start=0, so one held Start produces exactly one multiply.
- Busy or DONE: ClearA_LoadB is ignored. Sw changes have no effect after Start.
- Back-to-back runs without ClearA_LoadB reuse B (the previous low half) as the multiplier. This is intentional.
- Arithmetic: signed result is the exact two's-complement product over 2·WIDTH bits. Unsigned result is the exact unsigned product. No overflow is possible.
- Count register width: $clog2(WIDTH)+1.

## Timing
- Start sampled high in IDLE at edge t0 → CLEAR in cycle t0..t0+1.
- ADD/SHIFT pairs occupy 2·WIDTH cycles.
- Done rises at edge t0+2·WIDTH+2. For WIDTH=8 this is 18 cycles after the Start sample edge.
- Busy rises at t0+1 and falls at the same edge that Done rises.
- Done falls on the first edge after Start is observed low in DONE.
- Outputs are register outputs, with no combinational path from inputs.
- Reset asserted mid-operation aborts immediately. State and outputs take their reset values on that edge. No partial product is retained.

## Structure
- Package mult_pkg:
  - typedef enum logic [2:0] mult_state_t {IDLE, CLEAR, ADD, SHIFT, DONE}.
  - Localparams for the minimum and maximum WIDTH.
- Sub-module mult_shift_reg #(WIDTH): a register with synchronous clear, parallel load, and right shift with serial in/out. Control priority is clear > shift > load.
  - Instantiated twice, for A and B.
  - The A instance's serial out feeds the B instance's serial in.
- Adder/subtractor (WIDTH+1 bits), X flop, S register and FSM live in mult_core.

## Test plan
- WIDTH=8, load B=0xFF, S=0xFF, Signed_Mode=0, Start → Done at t0+18; Aval=0xFE, Bval=0x01, Xval=0.
- WIDTH=8, B=0xFF, S=0xFF, Signed_Mode=1 → Aval=0x00, Bval=0x01, Xval=0 (−1 × −1 = 1).
- WIDTH=8, B=0x7F, S=0x80, Signed_Mode=1 → Aval=0xC0, Bval=0x80, Xval=1 (−16256).
- WIDTH=4, B=0x8, S=0x8, Signed_Mode=1 → Aval=0x4, Bval=0x0 (−8 × −8 = 64).
- Hold Start high past Done → exactly one multiply. Pulse ClearA_LoadB while Busy → no effect. Release Start and re-press without a load → the multiplier is the previous Bval.
- Assert Reset at cycle t0+7 → next edge: Aval=Bval=0, Xval=0, Busy=0, Done=0, state IDLE.

Source files
------------

// File: rtl/mult_pkg.sv
// Shared types and limits for the shift-add multiplier core.
package mult_pkg;
  localparam int unsigned MULT_WIDTH_MIN = 2;
  localparam int unsigned MULT_WIDTH_MAX = 32;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    ADD,
    SHIFT,
    DONE
  } mult_state_t;
endpackage

// File: rtl/mult_shift_reg.sv
// Register with synchronous clear, right shift with serial in, and parallel load.
// Priority is clear > shift > load; the serial-out bit is simply q_o[0].
module mult_shift_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             clr_i,
  input  logic             shift_i,
  input  logic             load_i,
  input  logic             sin_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);
  logic [WIDTH-1:0] q_q;

  always_ff @(posedge clk_i) begin
    if (clr_i)        q_q <= '0;
    else if (shift_i) q_q <= {sin_i, q_q[WIDTH-1:1]};
    else if (load_i)  q_q <= d_i;
  end

  assign q_o = q_q;
endmodule

// File: rtl/mult_core.sv
// Shift-add multiplier: A/B shift registers, S multiplicand, X sign/carry bit and
// a sequencing FSM. Signed mode subtracts the final partial product.
module mult_core
  import mult_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic             ClearA_LoadB,
  input  logic             Signed_Mode,
  input  logic [WIDTH-1:0] Sw,
  output logic [WIDTH-1:0] Aval,
  output logic [WIDTH-1:0] Bval,
  output logic             Xval,
  output logic             Busy,
  output logic             Done
);
  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  mult_state_t      state_q, state_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic             x_q, x_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             mode_q, mode_d;
  logic             busy_q, done_q;

  logic [WIDTH-1:0] a_val, b_val;
  logic             a_clr, a_shift, a_load;
  logic             b_clr, b_shift, b_load;
  logic [WIDTH:0]   a_ext, s_ext, sum;
  logic             last;

  assign a_ext = {mode_q & a_val[WIDTH-1], a_val};
  assign s_ext = {mode_q & s_q[WIDTH-1], s_q};
  assign last  = (cnt_q == LAST_CNT);
  // The MSB of a two's-complement multiplier has negative weight.
  assign sum   = (mode_q && last) ? (a_ext - s_ext) : (a_ext + s_ext);

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    x_d     = x_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    a_clr   = Reset;
    a_shift = 1'b0;
    a_load  = 1'b0;
    b_clr   = Reset;
    b_shift = 1'b0;
    b_load  = 1'b0;
    case (state_q)
      IDLE: begin
        if (ClearA_LoadB) begin
          a_clr  = 1'b1;
          x_d    = 1'b0;
          b_load = 1'b1;
        end else if (Start) begin
          s_d     = Sw;
          mode_d  = Signed_Mode;
          state_d = CLEAR;
        end
      end
      CLEAR: begin
        a_clr   = 1'b1;
        x_d     = 1'b0;
        cnt_d   = '0;
        state_d = ADD;
      end
      ADD: begin
        if (b_val[0]) begin
          a_load = 1'b1;
          x_d    = sum[WIDTH];
        end
        state_d = SHIFT;
      end
      SHIFT: begin
        a_shift = 1'b1;
        b_shift = 1'b1;
        if (!mode_q) x_d = 1'b0;
        cnt_d   = cnt_q + 1'b1;
        state_d = last ? DONE : ADD;
      end
      DONE: begin
        if (!Start) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Busy/Done are registered from the current state, so they trail it by one edge.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
      s_q     <= '0;
      x_q     <= 1'b0;
      cnt_q   <= '0;
      mode_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      x_q     <= x_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      busy_q  <= (state_q == CLEAR) || (state_q == ADD) || (state_q == SHIFT);
      done_q  <= (state_q == DONE);
    end
  end

  mult_shift_reg #(.WIDTH(WIDTH)) u_areg (
    .clk_i  (Clk),
    .clr_i  (a_clr),
    .shift_i(a_shift),
    .load_i (a_load),
    .sin_i  (x_q),
    .d_i    (sum[WIDTH-1:0]),
    .q_o    (a_val)
  );

  mult_shift_reg #(.WIDTH(WIDTH)) u_breg (
    .clk_i  (Clk),
    .clr_i  (b_clr),
    .shift_i(b_shift),
    .load_i (b_load),
    .sin_i  (a_val[0]),
    .d_i    (Sw),
    .q_o    (b_val)
  );

  assign Aval = a_val;
  assign Bval = b_val;
  assign Xval = x_q;
  assign Busy = busy_q;
  assign Done = done_q;
endmodule
